// File: rtl/dm_access_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (port 0) and the debug/loader port (port 1).
// Define DM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dm_access_arbiter #(
  parameter int DW     = 8,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_rw,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_rw,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          dm_en,
  output logic          dm_rw,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    RD_RET  = 2'd3
  } state_t;

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_t        state_r, state_s;
  logic [1:0]    cnt_r, cnt_s;
  logic          owner_r, owner_s;
  logic          pick1_s;
  logic          p0_gnt_r, p0_gnt_s, p1_gnt_r, p1_gnt_s;
  logic          p0_rvalid_r, p0_rvalid_s, p1_rvalid_r, p1_rvalid_s;
  logic [DW-1:0] p0_rdata_r, p0_rdata_s, p1_rdata_r, p1_rdata_s;
  logic          dm_en_r, dm_en_s, dm_rw_r, dm_rw_s;
  logic [AW-1:0] dm_addr_r, dm_addr_s;
  logic [DW-1:0] dm_wdata_r, dm_wdata_s;
  logic          busy_r, busy_s;

`ifdef DM_ARB_RR_EN
  logic last_r, last_s;

  // On a tie the port not served most recently wins; last_r=1 means port 1 was last
  assign pick1_s = p1_req & (~p0_req | ~last_r);
  assign last_s  = (p0_gnt_s | p1_gnt_s) ? pick1_s : last_r;

  // Last-served pointer, reset to port 1 so port 0 wins first
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_r <= 1'b1;
    end else begin
      last_r <= last_s;
    end
  end
`else
  assign pick1_s = p1_req & ~p0_req;
`endif

  // Next-state and next-output decode; dm_rw/addr/wdata double as the latched request fields
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    owner_s     = owner_r;
    p0_gnt_s    = 1'b0;
    p1_gnt_s    = 1'b0;
    p0_rvalid_s = 1'b0;
    p1_rvalid_s = 1'b0;
    p0_rdata_s  = p0_rdata_r;
    p1_rdata_s  = p1_rdata_r;
    dm_en_s     = 1'b0;
    dm_rw_s     = dm_rw_r;
    dm_addr_s   = dm_addr_r;
    dm_wdata_s  = dm_wdata_r;
    case (state_r)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_s = ACCESS;
          owner_s = pick1_s;
          dm_en_s = 1'b1;
          if (pick1_s) begin
            p1_gnt_s   = 1'b1;
            dm_rw_s    = p1_rw;
            dm_addr_s  = p1_addr;
            dm_wdata_s = p1_wdata;
          end else begin
            p0_gnt_s   = 1'b1;
            dm_rw_s    = p0_rw;
            dm_addr_s  = p0_addr;
            dm_wdata_s = p0_wdata;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (dm_rw_r) begin
          state_s = IDLE;
        end else begin
          state_s = RD_WAIT;
          cnt_s   = LAT_LOAD;
        end
      end
      RD_WAIT: begin
        if (cnt_r == 2'd0) begin
          state_s = RD_RET;
          if (owner_r) begin
            p1_rdata_s  = dm_rdata;
            p1_rvalid_s = 1'b1;
          end else begin
            p0_rdata_s  = dm_rdata;
            p0_rvalid_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      RD_RET: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, counter and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      owner_r     <= 1'b0;
      p0_gnt_r    <= 1'b0;
      p1_gnt_r    <= 1'b0;
      p0_rvalid_r <= 1'b0;
      p1_rvalid_r <= 1'b0;
      p0_rdata_r  <= '0;
      p1_rdata_r  <= '0;
      dm_en_r     <= 1'b0;
      dm_rw_r     <= 1'b0;
      dm_addr_r   <= '0;
      dm_wdata_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      owner_r     <= owner_s;
      p0_gnt_r    <= p0_gnt_s;
      p1_gnt_r    <= p1_gnt_s;
      p0_rvalid_r <= p0_rvalid_s;
      p1_rvalid_r <= p1_rvalid_s;
      p0_rdata_r  <= p0_rdata_s;
      p1_rdata_r  <= p1_rdata_s;
      dm_en_r     <= dm_en_s;
      dm_rw_r     <= dm_rw_s;
      dm_addr_r   <= dm_addr_s;
      dm_wdata_r  <= dm_wdata_s;
      busy_r      <= busy_s;
    end
  end

  assign p0_gnt    = p0_gnt_r;
  assign p1_gnt    = p1_gnt_r;
  assign p0_rvalid = p0_rvalid_r;
  assign p1_rvalid = p1_rvalid_r;
  assign p0_rdata  = p0_rdata_r;
  assign p1_rdata  = p1_rdata_r;
  assign dm_en     = dm_en_r;
  assign dm_rw     = dm_rw_r;
  assign dm_addr   = dm_addr_r;
  assign dm_wdata  = dm_wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter: one instance at RD_LAT=1 with a RAM model, one at RD_LAT=3.
module tb_dm_access_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_clr;
  logic       p0_req, p0_rw, p1_req, p1_rw;
  logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic       dm_en, dm_rw, busy;
  logic [7:0] dm_addr, dm_wdata, dm_rdata;

  logic       q0_req, q0_rw, q1_req, q1_rw;
  logic [7:0] q0_addr, q0_wdata, q1_addr, q1_wdata;
  logic       q0_gnt, q0_rvalid, q1_gnt, q1_rvalid;
  logic [7:0] q0_rdata, q1_rdata;
  logic       q_dm_en, q_dm_rw, q_busy;
  logic [7:0] q_dm_addr, q_dm_wdata, q_dm_rdata;
  logic [7:0] s0, s1;

  logic [7:0] mem [0:255];
  int         en_cnt = 0, g1_cnt = 0, en3_cnt = 0;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  dm_access_arbiter #(.DW(8), .AW(8), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .dm_en(dm_en), .dm_rw(dm_rw), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .busy(busy)
  );

  dm_access_arbiter #(.DW(8), .AW(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .p0_req(q0_req), .p0_rw(q0_rw), .p0_addr(q0_addr), .p0_wdata(q0_wdata),
    .p0_gnt(q0_gnt), .p0_rvalid(q0_rvalid), .p0_rdata(q0_rdata),
    .p1_req(q1_req), .p1_rw(q1_rw), .p1_addr(q1_addr), .p1_wdata(q1_wdata),
    .p1_gnt(q1_gnt), .p1_rvalid(q1_rvalid), .p1_rdata(q1_rdata),
    .dm_en(q_dm_en), .dm_rw(q_dm_rw), .dm_addr(q_dm_addr), .dm_wdata(q_dm_wdata),
    .dm_rdata(q_dm_rdata), .busy(q_busy)
  );

  // Latency-1 RAM; 8'h5A on the read bus outside the data window exposes timing slips
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 16) ? 8'h11 : ((i == 32) ? 8'h22 : 8'h00);
      dm_rdata <= 8'h5A;
    end else begin
      if (dm_en && dm_rw) mem[dm_addr] <= dm_wdata;
      dm_rdata <= (dm_en && !dm_rw) ? mem[dm_addr] : 8'h5A;
    end
  end

  // Latency-3 ROM holding 8'hFF at address 8'h03
  always @(posedge clk) begin
    s0 <= (q_dm_en && !q_dm_rw) ? ((q_dm_addr == 8'h03) ? 8'hFF : 8'h00) : 8'h5A;
    s1 <= s0;
    q_dm_rdata <= s1;
  end

  always @(posedge clk) begin
    if (dm_en) en_cnt <= en_cnt + 1;
    if (p1_gnt) g1_cnt <= g1_cnt + 1;
    if (q_dm_en) en3_cnt <= en3_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int gq[$];
    int en_base, g1_base, en3_base;
    reset = 1'b0; mem_clr = 1'b1;
    p0_req = 1'b0; p0_rw = 1'b0; p0_addr = 8'h00; p0_wdata = 8'h00;
    p1_req = 1'b0; p1_rw = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
    q0_req = 1'b0; q0_rw = 1'b0; q0_addr = 8'h00; q0_wdata = 8'h00;
    q1_req = 1'b0; q1_rw = 1'b0; q1_addr = 8'h00; q1_wdata = 8'h00;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_dm_en", dm_en, 1'b0);
    chk("rst_gnt", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, 4'h0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 16'h0000);
    chk("rst_dm_bus", {dm_rw, dm_addr, dm_wdata}, 17'h0);
    mem_clr = 1'b0; reset = 1'b1;
    step();

    // Port 0 write 8'hFF to 8'h03
    p0_req = 1'b1; p0_rw = 1'b1; p0_addr = 8'h03; p0_wdata = 8'hFF;
    step();
    chk("wr_gnt", {p0_gnt, p1_gnt}, 2'b10);
    chk("wr_strobe", {dm_en, dm_rw, dm_addr, dm_wdata}, {1'b1, 1'b1, 8'h03, 8'hFF});
    chk("wr_busy", busy, 1'b1);
    p0_req = 1'b0;
    step();
    chk("wr_end", {p0_gnt, dm_en, busy}, 3'b000);
    chk("wr_hold_addr", dm_addr, 8'h03);

    // Port 0 read of 8'h03, RD_LAT=1
    p0_req = 1'b1; p0_rw = 1'b0; p0_addr = 8'h03;
    step();
    chk("rd_gnt", {p0_gnt, dm_en, dm_rw}, 3'b110);
    p0_req = 1'b0;
    step();
    chk("rd_wait", {dm_en, p0_rvalid, busy}, 3'b001);
    step();
    chk("rd_ret_valid", {p0_rvalid, p1_rvalid}, 2'b10);
    chk("rd_ret_data", p0_rdata, 8'hFF);
    chk("rd_other_rdata", p1_rdata, 8'h00);
    step();
    chk("rd_idle", {p0_rvalid, busy}, 2'b00);
    chk("rd_rdata_hold", p0_rdata, 8'hFF);

    // Same read at RD_LAT=3: two extra wait cycles, single strobe
    en3_base = en3_cnt;
    q0_req = 1'b1; q0_rw = 1'b0; q0_addr = 8'h03;
    step();
    chk("l3_gnt", {q0_gnt, q_dm_en}, 2'b11);
    q0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("l3_wait", {q_dm_en, q0_rvalid, q_busy}, 3'b001);
    end
    step();
    chk("l3_ret", {q0_rvalid, q0_rdata}, {1'b1, 8'hFF});
    step();
    chk("l3_idle", {q0_rvalid, q_busy}, 2'b00);
    chk("l3_one_strobe", en3_cnt - en3_base, 1);

    // Reset during RD_WAIT of a port 1 read
    p1_req = 1'b1; p1_rw = 1'b0; p1_addr = 8'h20;
    step();
    chk("rr_p1_gnt", {p0_gnt, p1_gnt}, 2'b01);
    p1_req = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("arst_outs", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, dm_en, dm_rw, busy}, 7'h00);
    chk("arst_buses", {dm_addr, dm_wdata, p0_rdata, p1_rdata}, 32'h0);
    step();
    chk("arst_no_rvalid", p1_rvalid, 1'b0);
    reset = 1'b1;
    step();
    chk("arst_no_rvalid2", {p1_rvalid, busy}, 2'b00);
    p1_req = 1'b1; p1_rw = 1'b0; p1_addr = 8'h20;
    step();
    chk("post_rst_gnt", {p1_gnt, dm_en, dm_addr}, {1'b1, 1'b1, 8'h20});
    p1_req = 1'b0;
    step(); step();
    chk("post_rst_ret", {p1_rvalid, p1_rdata, p0_rdata}, {1'b1, 8'h22, 8'h00});
    step();

    // Continuous contention
    p0_req = 1'b1; p0_rw = 1'b0; p0_addr = 8'h10;
    p1_req = 1'b1; p1_rw = 1'b0; p1_addr = 8'h20;
    for (int i = 0; i < 16; i++) begin
      step();
      if (p0_gnt) gq.push_back(0);
      if (p1_gnt) gq.push_back(1);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("arb_count", gq.size(), 4);
    for (int i = 0; i < 4; i++) begin
`ifdef DM_ARB_RR_EN
      chk($sformatf("arb_grant%0d", i), (i < gq.size()) ? gq[i] : 9, i % 2);
`else
      chk($sformatf("arb_grant%0d", i), (i < gq.size()) ? gq[i] : 9, 0);
`endif
    end
    step();
    chk("arb_idle", busy, 1'b0);
    chk("arb_rdata", {p0_rdata, p1_rdata}, 16'h1122);

    // p1 request pulsed while busy must be ignored
    en_base = en_cnt; g1_base = g1_cnt;
    p0_req = 1'b1; p0_rw = 1'b0; p0_addr = 8'h03;
    step();
    chk("busy_p0_gnt", p0_gnt, 1'b1);
    p0_req = 1'b0;
    p1_req = 1'b1; p1_rw = 1'b0; p1_addr = 8'h20;
    step();
    p1_req = 1'b0;
    chk("busy_mid", busy, 1'b1);
    step();
    chk("busy_ret", {p0_rvalid, p0_rdata}, {1'b1, 8'hFF});
    step(); step(); step();
    chk("busy_no_p1_gnt", g1_cnt - g1_base, 0);
    chk("busy_one_strobe", en_cnt - en_base, 1);
    chk("busy_final", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
